// File: rtl/hilo_acc_unit.sv
// rtl/hilo_acc_unit.sv - HI/LO special registers with a 2-stage pipelined {hi,lo} accumulate path
module hilo_acc_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_hi,
  input  logic                we_lo,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic                acc_valid,
  input  logic [1:0]          acc_op,
  input  logic [2*DATA_W-1:0] acc_data,
  output logic                acc_ready,
  output logic                busy,
  output logic                wr_stall,
  output logic                acc_done,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o
);

  localparam logic       ACC_ON = (ACC_EN != 0);
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;

  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  // Request latched at the accept edge; S1 runs on the following edge
  logic                r_p_valid;
  logic [1:0]          r_p_op;
  logic [2*DATA_W-1:0] r_p_data;
  logic                r_s2_valid;
  logic [1:0]          r_s2_op;
  logic [DATA_W-1:0]   r_s2_hi;
  logic                r_s2_cb;
  logic                r_done;

  logic                w_busy;
  logic                w_accept;
  logic [DATA_W:0]     w_lo_sum;
  logic [DATA_W-1:0]   w_hi_sum;

  assign w_busy    = r_p_valid | r_s2_valid;
  assign acc_ready = ACC_ON & ~w_busy;
  assign w_accept  = acc_valid & acc_ready;
  assign wr_stall  = w_busy & (we_hi | we_lo);
  assign busy      = w_busy;
  assign acc_done  = r_done;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

  // Top bit of the extended low result is the carry (ADD) or borrow (SUB)
  always_comb begin
    w_lo_sum = {1'b0, r_lo} + {1'b0, r_p_data[DATA_W-1:0]};
    if (r_p_op == OP_SUB) begin
      w_lo_sum = {1'b0, r_lo} - {1'b0, r_p_data[DATA_W-1:0]};
    end
  end

  always_comb begin
    w_hi_sum = r_hi + r_s2_hi + DATA_W'(r_s2_cb);
    if (r_s2_op == OP_SUB) begin
      w_hi_sum = r_hi - r_s2_hi - DATA_W'(r_s2_cb);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_p_valid  <= 1'b0;
      r_p_op     <= '0;
      r_p_data   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_op    <= '0;
      r_s2_hi    <= '0;
      r_s2_cb    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= r_s2_valid;
      r_s2_valid <= r_p_valid;
      r_p_valid  <= w_accept;
      if (w_accept) begin
        r_p_op   <= acc_op;
        r_p_data <= acc_data;
      end
      if (r_p_valid) begin
        r_s2_op <= r_p_op;
        r_s2_hi <= r_p_data[2*DATA_W-1:DATA_W];
        r_s2_cb <= w_lo_sum[DATA_W];
        if (r_p_op == OP_ADD || r_p_op == OP_SUB) begin
          r_lo <= w_lo_sum[DATA_W-1:0];
        end else if (r_p_op == OP_LOAD) begin
          r_lo <= r_p_data[DATA_W-1:0];
        end
      end
      if (r_s2_valid) begin
        if (r_s2_op == OP_ADD || r_s2_op == OP_SUB) begin
          r_hi <= w_hi_sum;
        end else if (r_s2_op == OP_LOAD) begin
          r_hi <= r_s2_hi;
        end
      end
      // Direct writes only land while idle, so they never collide with the pipeline
      if (!w_busy && we_hi) begin
        r_hi <= hi_i;
      end
      if (!w_busy && we_lo) begin
        r_lo <= lo_i;
      end
    end
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// tb/tb_hilo_acc_unit.sv - randomized bench for hilo_acc_unit against a 64-bit behavioural model
module tb_hilo_acc_unit;

  logic        clk;
  logic        rst;
  logic        we_hi, we_lo;
  logic [31:0] hi_i, lo_i;
  logic        acc_valid;
  logic [1:0]  acc_op;
  logic [63:0] acc_data;
  logic        acc_ready, busy, wr_stall, acc_done;
  logic [31:0] hi_o, lo_o;
  logic        n_acc_ready, n_busy, n_wr_stall, n_acc_done;
  logic [31:0] n_hi_o, n_lo_o;

  hilo_acc_unit #(.DATA_W(32), .ACC_EN(1)) dut (
    .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
    .acc_valid(acc_valid), .acc_op(acc_op), .acc_data(acc_data),
    .acc_ready(acc_ready), .busy(busy), .wr_stall(wr_stall), .acc_done(acc_done),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  hilo_acc_unit #(.DATA_W(32), .ACC_EN(0)) dut_noacc (
    .clk(clk), .rst(rst), .we_hi(we_hi), .we_lo(we_lo), .hi_i(hi_i), .lo_i(lo_i),
    .acc_valid(acc_valid), .acc_op(acc_op), .acc_data(acc_data),
    .acc_ready(n_acc_ready), .busy(n_busy), .wr_stall(n_wr_stall), .acc_done(n_acc_done),
    .hi_o(n_hi_o), .lo_o(n_lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: architectural {hi,lo} updated with whole 64-bit arithmetic
  int          phase;
  logic [1:0]  m_op;
  logic [63:0] m_data, m_res;
  logic [31:0] m_hi, m_lo, x_hi, x_lo;
  logic        m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; m_hi = '0; m_lo = '0; x_hi = '0; x_lo = '0; m_done = 1'b0;
    m_op = '0; m_data = '0; m_res = '0;
  endtask

  task automatic model_edge();
    logic [63:0] cur;
    m_done = (phase == 2);
    if (phase == 1) begin
      cur = {m_hi, m_lo};
      case (m_op)
        2'b00:   m_res = cur + m_data;
        2'b01:   m_res = cur - m_data;
        2'b10:   m_res = m_data;
        default: m_res = cur;
      endcase
      m_lo  = m_res[31:0];
      phase = 2;
    end else if (phase == 2) begin
      m_hi  = m_res[63:32];
      phase = 0;
    end else begin
      if (we_hi) m_hi = hi_i;
      if (we_lo) m_lo = lo_i;
      if (acc_valid) begin
        m_op = acc_op; m_data = acc_data; phase = 1;
      end
    end
    if (we_hi) x_hi = hi_i;
    if (we_lo) x_lo = lo_i;
  endtask

  task automatic idle();
    we_hi = 0; we_lo = 0; hi_i = '0; lo_i = '0;
    acc_valid = 0; acc_op = 2'b11; acc_data = '0;
  endtask

  task automatic cycle();
    #1;
    check("wr_stall", wr_stall, (phase != 0) && (we_hi || we_lo));
    check("acc_ready", acc_ready, phase == 0);
    check("noacc_stall", n_wr_stall, 0);
    check("noacc_ready", n_acc_ready, 0);
    model_edge();
    @(posedge clk);
    #1;
    check("hi_o", hi_o, m_hi);
    check("lo_o", lo_o, m_lo);
    check("busy", busy, phase != 0);
    check("acc_done", acc_done, m_done);
    check("noacc_hi", n_hi_o, x_hi);
    check("noacc_lo", n_lo_o, x_lo);
    check("noacc_busy_done", {n_busy, n_acc_done}, 0);
  endtask

  task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
    idle(); we_hi = 1; we_lo = 1; hi_i = h; lo_i = l;
    cycle(); idle();
  endtask

  task automatic run_acc(input logic [1:0] op, input logic [63:0] d);
    idle(); acc_valid = 1; acc_op = op; acc_data = d;
    cycle(); idle();
    cycle(); cycle();
  endtask

  initial begin
    idle();
    rst = 0;
    model_reset();
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_flags", {busy, acc_done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;

    // Independent HI then LO writes
    we_hi = 1; hi_i = 32'h1234_5678;
    cycle(); idle();
    check("tp1_hi", hi_o, 32'h1234_5678);
    check("tp1_lo", lo_o, 0);
    we_lo = 1; lo_i = 32'hDEAD_BEEF;
    cycle(); idle();
    check("tp1_lo2", lo_o, 32'hDEAD_BEEF);
    check("tp1_hi2", hi_o, 32'h1234_5678);

    // Carry crosses halves, done pulses once
    write_hl(32'h0, 32'hFFFF_FFFF);
    acc_valid = 1; acc_op = 2'b00; acc_data = 64'h1;
    cycle(); idle();
    cycle();
    check("tp2_lo_e1", lo_o, 0);
    check("tp2_hi_e1", hi_o, 0);
    cycle();
    check("tp2_hi_e2", hi_o, 1);
    check("tp2_done", acc_done, 1);
    cycle();
    check("tp2_done_off", acc_done, 0);

    // SUB wrap, LOAD, NOP
    write_hl(32'h0, 32'h0);
    run_acc(2'b01, 64'h1);
    check("tp3_sub", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);
    run_acc(2'b10, 64'hAAAA_0000_5555_0000);
    check("tp3_load", {hi_o, lo_o}, 64'hAAAA_0000_5555_0000);
    run_acc(2'b11, 64'h1234);
    check("tp3_nop", {hi_o, lo_o}, 64'hAAAA_0000_5555_0000);
    check("tp3_nop_done", acc_done, 1);

    // Held write and held accumulate during busy
    acc_valid = 1; acc_op = 2'b00; acc_data = 64'h10;
    cycle();
    we_lo = 1; lo_i = 32'h77; acc_data = 64'h5;
    cycle(); cycle(); cycle(); idle();
    check("tp4_lo", lo_o, 32'h77);
    cycle(); cycle(); cycle();

    // Same-edge write and ADD from idle
    write_hl(32'h9, 32'h0);
    we_lo = 1; lo_i = 32'h5; acc_valid = 1; acc_op = 2'b00; acc_data = 64'h3;
    cycle(); idle();
    check("tp5_lo_e0", lo_o, 5);
    cycle();
    check("tp5_lo_e1", lo_o, 8);
    cycle();
    check("tp5_hi", hi_o, 9);

    // Reset mid-operation drops the accumulate
    write_hl(32'h1, 32'h2);
    acc_valid = 1; acc_op = 2'b00; acc_data = 64'h100;
    cycle(); idle();
    #2;
    rst = 0;
    #1;
    check("tp6_hi", hi_o, 0);
    check("tp6_lo", lo_o, 0);
    check("tp6_busy", busy, 0);
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check("tp6_done", acc_done, 0);
    end
    @(negedge clk);
    rst = 1;
    run_acc(2'b00, 64'h1_0000_0002);
    check("tp6_fresh", {hi_o, lo_o}, 64'h1_0000_0002);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      we_hi     = ($urandom_range(0, 3) == 0);
      we_lo     = ($urandom_range(0, 3) == 0);
      hi_i      = $urandom;
      lo_i      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      acc_valid = ($urandom_range(0, 1) == 1);
      acc_op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       acc_data = 64'h1;
        1:       acc_data = 64'hFFFF_FFFF_FFFF_FFFF;
        default: acc_data = {$urandom, $urandom};
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_acc_unit.md
Name: hilo_acc_unit

Overview:
- Parametrised HI/LO special-register unit, successor to the plain HI/LO register.
- Provides direct MTHI/MTLO-style writes with independent HI and LO enables.
- Adds a 2-stage pipelined accumulate path on the concatenated {hi,lo} pair: MADD/MSUB/load from the multiplier.
- Sits between the EX/MEM multiply result path and the WB stage; hi_o/lo_o feed MFHI/MFLO.

Parameters:
- DATA_W, 32, width of each of HI and LO; the accumulator is 2*DATA_W bits.
- ACC_EN, 1, 1 = accumulate path present; 0 = acc_ready tied 0, accumulate logic removed.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- we_hi  in  1  direct write enable for HI.
- we_lo  in  1  direct write enable for LO.
- hi_i  in  DATA_W  direct write data for HI.
- lo_i  in  DATA_W  direct write data for LO.
- acc_valid  in  1  accumulate request.
- acc_op  in  2  00 ADD, 01 SUB, 10 LOAD, 11 NOP.
- acc_data  in  2*DATA_W  operand; [2*DATA_W-1:DATA_W] is the HI half.
- acc_ready  out  1  unit can accept an accumulate request this cycle.
- busy  out  1  accumulate in flight.
- wr_stall  out  1  direct write refused this cycle; requester must hold the request.
- acc_done  out  1  one-cycle pulse after an accumulate commits.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.

Behaviour:
- Reset:
  - rst low clears hi_o, lo_o, stage registers, busy, acc_done to 0 immediately (asynchronous).
  - A request present on the first rising edge after rst deasserts is accepted normally.
- Direct write:
  - Accepted at a clock edge when busy=0.
  - we_hi loads hi_i and we_lo loads lo_i; each half is independent, so both may load together.
  - Visible on hi_o/lo_o after that edge.
- acc_ready = ACC_EN & ~busy. A request is accepted at an edge where acc_valid & acc_ready.
- Simultaneous direct write and accumulate request while idle: both are accepted; the direct write is older and commits at that edge. The accumulate's S1 samples the updated value at the next edge.
- Pipeline, with the accept edge named E0:
  - Stage S1 (edge E1): S1 registers op and operand and computes the low sum L = lo_o ± acc_data[DATA_W-1:0], with carry/borrow.
  - At E1: lo_o <= L[DATA_W-1:0] for ADD/SUB; lo_o <= acc_data low half for LOAD. The carry/borrow is registered.
  - Stage S2 (edge E2): hi_o <= hi_o ± acc_data high half ± the registered carry/borrow for ADD/SUB; hi_o <= acc_data high half for LOAD.
  - NOP writes nothing but still traverses both stages.
  - acc_done is high for exactly the cycle after E2.
- busy:
  - High from after E0 until E2 inclusive.
  - Deasserts after E2; a new accumulate is accepted at E2+1 at the earliest.
  - Throughput is one accumulate per 3 cycles.
- Arithmetic:
  - Modulo 2^(2*DATA_W) two's complement; no overflow flag and no saturation.
  - SUB computes {hi,lo} - acc_data.
- Stall rule: wr_stall = busy & (we_hi | we_lo). Writes during busy are ignored and must be re-presented by the requester.
- acc_valid while busy is ignored (acc_ready=0); the requester holds it.
- Intermediate state: between E1 and E2, lo_o already holds the new LO while hi_o is still old. Consumers must not read while busy, so the stall/forward logic upstream checks busy.
- Reset mid-operation: the in-flight accumulate is dropped, no acc_done is produced, and hi/lo are 0.
- ACC_EN=0: acc_valid is ignored, busy=0, acc_done=0, and direct writes are never stalled.

Test Plan:
- Reset then we_hi=1, hi_i=32'h1234_5678, we_lo=0 -> hi_o=32'h1234_5678 next cycle, lo_o=0; then we_lo=1, lo_i=32'hDEAD_BEEF -> lo_o updates, hi_o unchanged.
- hi/lo=0/32'hFFFF_FFFF, ADD acc_data=64'h1 -> after E1 lo_o=0; after E2 hi_o=1 (carry crosses halves); acc_done pulses once, 3 cycles after accept.
- hi/lo=0/0, SUB acc_data=64'h1 -> {hi_o,lo_o}=64'hFFFF_FFFF_FFFF_FFFF (wrap); LOAD 64'hAAAA_0000_5555_0000 -> exact load; NOP -> unchanged, acc_done still pulses.
- ADD accepted, then we_lo=1 held during busy -> wr_stall=1 for 2 cycles, then write lands after the accumulate result; acc_valid held during busy is accepted only once busy drops.
- Same-edge we_lo=1, lo_i=5 and ADD acc_data=3 from idle -> lo_o=5, then 8; hi_o unchanged.
- rst asserted the cycle after accept -> all outputs 0 asynchronously, no acc_done; after release, a fresh ADD behaves normally.
